// File: rtl/two_demux32_buf.sv
// Buffered 1-to-2 demultiplexer: one producer steers words into two independent
// per-destination FIFOs, each drained by its own valid/ready consumer.
module two_demux32_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] In,
  input  logic             Sel,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] Out0,
  output logic             Out0Valid,
  input  logic             Out0Ready,
  output logic [WIDTH-1:0] Out1,
  output logic             Out1Valid,
  input  logic             Out1Ready,
  output logic [CNTW-1:0]  Count0,
  output logic [CNTW-1:0]  Count1
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_e;

  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [PW-1:0]    wptr_q [2];
  logic [PW-1:0]    wptr_d [2];
  logic [PW-1:0]    rptr_q [2];
  logic [PW-1:0]    rptr_d [2];
  logic [CNTW-1:0]  cnt_q  [2];
  logic [CNTW-1:0]  cnt_d  [2];
  fifo_state_e      state  [2];

  logic [1:0] out_rdy;
  logic [1:0] valid;
  logic [1:0] full;
  logic [1:0] push;
  logic [1:0] pop;

  assign out_rdy = {Out1Ready, Out0Ready};

  // FIFO state is a pure function of occupancy, so it is decoded rather than stored.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if (cnt_q[k] == '0)
        state[k] = EMPTY;
      else if (cnt_q[k] == CNTW'(DEPTH))
        state[k] = FULL;
      else
        state[k] = PARTIAL;
      valid[k] = (state[k] != EMPTY);
      full[k]  = (state[k] == FULL);
    end
  end

  // A full FIFO refuses input even while it is being drained in the same cycle.
  assign InReady = Sel ? !full[1] : !full[0];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      push[k]   = InValid && InReady && (Sel == 1'(k));
      pop[k]    = valid[k] && out_rdy[k];
      wptr_d[k] = wptr_q[k] + PW'(push[k]);
      rptr_d[k] = rptr_q[k] + PW'(pop[k]);
      cnt_d[k]  = cnt_q[k] + CNTW'(push[k]) - CNTW'(pop[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end else begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // Storage needs no reset: stale entries are masked by the valid flags.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k] && !reset)
        mem_q[k][wptr_q[k]] <= In;
    end
  end

  assign Out0Valid = valid[0];
  assign Out1Valid = valid[1];
  assign Out0      = valid[0] ? mem_q[0][rptr_q[0]] : '0;
  assign Out1      = valid[1] ? mem_q[1][rptr_q[1]] : '0;
  assign Count0    = cnt_q[0];
  assign Count1    = cnt_q[1];

endmodule
